// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM encoding and the mult/div stall lengths.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_t;

    // Counter load values; the stall lasts load+1 cycles because the count includes zero.
    localparam logic [4:0] MD_DIV_CYC = 5'd31;
    localparam logic [4:0] MD_MUL_CYC = 5'd3;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up-counter that sticks at all-ones.
// Used to count stall cycles for performance monitoring.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'd0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, mult/div wait, memory freeze.
// state   | meaning
// RUN     | normal issue; hazards are resolved combinationally
// MD_WAIT | mult/div in flight; front end held until md_cnt expires
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_jump,
    input  logic        id_jumpreg,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_we,
    output logic        idex_bubble,
    output logic        md_busy,
    output logic [15:0] stall_cycles
);

    md_state_t  state, state_nxt;
    logic [4:0] md_cnt, md_cnt_nxt;
    logic       mem_freeze;
    logic       load_use;

    assign mem_freeze = mem_req & ~mem_ready;
    assign load_use   = ex_memread & (ex_rt != 5'd0) &
                        ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= 5'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_we     = 1'b0;
        idex_bubble = 1'b0;
        md_busy     = 1'b0;

        case (state)
            RUN: begin
                if (md_start && !mem_freeze) begin
                    state_nxt  = MD_WAIT;
                    md_cnt_nxt = md_is_div ? MD_DIV_CYC : MD_MUL_CYC;
                end
                if (!mem_freeze) begin
                    if (ex_branch_taken) begin
                        pc_we       = 1'b1;
                        ifid_we     = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_we     = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        idex_we     = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (id_jump || id_jumpreg) begin
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_we    = 1'b1;
                    end else begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                        idex_we = 1'b1;
                    end
                end
            end
            MD_WAIT: begin
                // The wait keeps counting through a memory freeze; md_start is ignored here.
                md_busy = 1'b1;
                if (md_cnt == 5'd0) begin
                    state_nxt = RUN;
                end else begin
                    md_cnt_nxt = md_cnt - 5'd1;
                end
            end
            default: state_nxt = RUN;
        endcase

        // Reset holds every enable low independent of the register contents.
        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b0;
            idex_we     = 1'b0;
            idex_bubble = 1'b0;
            md_busy     = 1'b0;
        end
    end

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_we),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle sequences,
// and randomized traffic against a cycle-count reference model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, id_jump, id_jumpreg, ex_memread, ex_branch_taken;
    logic        md_start, md_is_div, mem_req, mem_ready;
    logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, md_busy;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: cycles of mult/div stall still ahead, and stall count.
    int m_rem = 0;
    int m_stall = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .id_jumpreg      (id_jumpreg),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .md_start        (md_start),
        .md_is_div       (md_is_div),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .ifid_flush      (ifid_flush),
        .idex_we         (idex_we),
        .idex_bubble     (idex_bubble),
        .md_busy         (md_busy),
        .stall_cycles    (stall_cycles)
    );

    // Output vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, md_busy}
    function automatic logic [5:0] model_out();
        logic freeze, busy, lu;
        if (rst_n !== 1'b1) return 6'b000000;
        freeze = mem_req & ~mem_ready;
        busy   = (m_rem > 0);
        lu     = ex_memread && (ex_rt != 0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        if (freeze)               return {5'b00000, busy};
        if (busy)                 return 6'b000001;
        if (ex_branch_taken)      return 6'b111110;
        if (lu)                   return 6'b000110;
        if (id_jump | id_jumpreg) return 6'b111100;
        return 6'b110100;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem   = 0;
            m_stall = 0;
        end else begin
            logic [5:0] o;
            o = model_out();
            if (!o[5] && m_stall < 65535) m_stall = m_stall + 1;
            if (m_rem > 0) m_rem = m_rem - 1;
            else if (md_start && !(mem_req && !mem_ready)) m_rem = md_is_div ? 32 : 4;
        end
    end

    function automatic logic [5:0] dut_out();
        return {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, md_busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0; id_jumpreg = 0;
        ex_memread = 0; ex_rt = 0; ex_branch_taken = 0;
        md_start = 0; md_is_div = 0; mem_req = 0; mem_ready = 0;
    endtask

    typedef struct {
        logic [4:0] rs, rt, xrt;
        logic       uses_rt, jump, jumpreg, memread, br, mreq, mrdy;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int busy_cnt, pc0_cnt, loops;
        logic [15:0] s0;

        vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 6'b110100, "idle"});
        vecs.push_back('{5'd8, 5'd0, 5'd8, 0, 0, 0, 1, 0, 0, 0, 6'b000110, "loaduse_rs"});
        vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 6'b110100, "load_r0"});
        vecs.push_back('{5'd1, 5'd9, 5'd9, 1, 0, 0, 1, 0, 0, 0, 6'b000110, "loaduse_rt"});
        vecs.push_back('{5'd1, 5'd9, 5'd9, 0, 0, 0, 1, 0, 0, 0, 6'b110100, "rt_unused"});
        vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, 0, 6'b111100, "jump"});
        vecs.push_back('{5'd4, 5'd0, 5'd4, 0, 0, 1, 1, 0, 0, 0, 6'b000110, "jr_loaduse"});
        vecs.push_back('{5'd4, 5'd0, 5'd4, 0, 0, 1, 1, 1, 0, 0, 6'b111110, "branch_over_lu"});
        vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 6'b000000, "mem_freeze"});
        vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 1, 6'b110100, "mem_ready"});
        vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 1, 1, 0, 6'b000000, "freeze_over_br"});

        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("reset_out", 32'(dut_out()), 32'(6'b000000));
        chk("reset_stall", 32'(stall_cycles), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            idle_inputs();
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rt = vecs[i].xrt;
            id_uses_rt = vecs[i].uses_rt; id_jump = vecs[i].jump; id_jumpreg = vecs[i].jumpreg;
            ex_memread = vecs[i].memread; ex_branch_taken = vecs[i].br;
            mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
            #1;
            chk(vecs[i].name, 32'(dut_out()), 32'(vecs[i].exp));
            chk("tbl_stall", 32'(stall_cycles), 32'(m_stall));
        end

        // Single load-use stall adds exactly one stall cycle.
        @(negedge clk); idle_inputs(); #1; s0 = stall_cycles;
        @(negedge clk); ex_memread = 1; ex_rt = 8; id_rs = 8; #1;
        chk("lu_out", 32'(dut_out()), 32'(6'b000110));
        @(negedge clk); idle_inputs(); #1;
        chk("lu_stall_inc", 32'(stall_cycles - s0), 32'd1);

        // Divide: 32 busy cycles, PC held throughout.
        @(negedge clk); md_start = 1; md_is_div = 1; #1;
        s0 = stall_cycles;
        chk("div_issue", 32'(dut_out()), 32'(6'b110100));
        busy_cnt = 0; pc0_cnt = 0; loops = 0;
        do begin
            @(negedge clk); idle_inputs(); md_start = (loops == 3); md_is_div = 1; #1;
            if (md_busy) busy_cnt++;
            if (md_busy && !pc_we) pc0_cnt++;
            loops++;
        end while (md_busy && loops < 100);
        chk("div_busy_len", busy_cnt, 32);
        chk("div_pc_held", pc0_cnt, 32);
        chk("div_stall_inc", 32'(stall_cycles - s0), 32'd32);
        chk("div_back_run", 32'(dut_out()), 32'(6'b110100));

        // Multiply with a 3-cycle memory freeze: still 4 busy cycles total.
        @(negedge clk); idle_inputs(); md_start = 1; #1;
        busy_cnt = 0; loops = 0;
        do begin
            @(negedge clk); idle_inputs();
            if (loops < 3) begin mem_req = 1; mem_ready = 0; end
            #1;
            if (loops < 3) chk("mul_freeze_out", 32'(dut_out()), 32'(6'b000001));
            if (md_busy) busy_cnt++;
            loops++;
        end while (md_busy && loops < 100);
        chk("mul_busy_len", busy_cnt, 4);

        // Branch in the issue cycle of a mult still starts the wait.
        @(negedge clk); idle_inputs(); md_start = 1; ex_branch_taken = 1; #1;
        chk("br_md_out", 32'(dut_out()), 32'(6'b111110));
        @(negedge clk); idle_inputs(); #1;
        chk("br_md_busy", 32'(md_busy), 32'd1);
        repeat (4) @(negedge clk);

        // Reset in the middle of a divide.
        @(negedge clk); idle_inputs(); md_start = 1; md_is_div = 1;
        repeat (10) @(negedge clk);
        idle_inputs(); #1;
        chk("pre_rst_busy", 32'(md_busy), 32'd1);
        rst_n = 1'b0; #1;
        chk("mid_rst_out", 32'(dut_out()), 32'(6'b000000));
        chk("mid_rst_stall", 32'(stall_cycles), 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("post_rst_run", 32'(dut_out()), 32'(6'b110100));

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            id_uses_rt      = ($urandom_range(0, 1) == 1);
            ex_memread      = ($urandom_range(0, 9) < 3);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            id_jump         = ($urandom_range(0, 9) == 0);
            id_jumpreg      = ($urandom_range(0, 9) == 0);
            md_start        = ($urandom_range(0, 19) == 0);
            md_is_div       = ($urandom_range(0, 1) == 1);
            mem_req         = ($urandom_range(0, 4) == 0);
            mem_ready       = ($urandom_range(0, 1) == 1);
            #1;
            chk("rand_out", 32'(dut_out()), 32'(model_out()));
            chk("rand_stall", 32'(stall_cycles), 32'(m_stall));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have port id_rs  in  5  rs field of instruction in IF/ID.
REQ-004 SHALL have port id_rt  in  5  rt field of instruction in IF/ID.
REQ-005 SHALL have port id_uses_rt  in  1  ID instruction reads rt.
REQ-006 SHALL have port id_jump  in  1  j/jal decoded in ID.
REQ-007 SHALL have port id_jumpreg  in  1  jr/jalr decoded in ID (reads rs).
REQ-008 SHALL have port ex_memread  in  1  load in ID/EX.
REQ-009 SHALL have port ex_rt  in  5  destination of the load in ID/EX.
REQ-010 SHALL have port ex_branch_taken  in  1  branch resolved taken in EX.
REQ-011 SHALL have port md_start  in  1  mult/div issuing in EX this cycle.
REQ-012 SHALL have port md_is_div  in  1  qualifies md_start: 1 = div, 0 = mult.
REQ-013 SHALL have port mem_req  in  1  MEM stage accessing data memory.
REQ-014 SHALL have port mem_ready  in  1  data memory completes this cycle.
REQ-015 SHALL have port pc_we  out  1  PC write enable.
REQ-016 SHALL have port ifid_we  out  1  IF/ID register write enable.
REQ-017 SHALL have port ifid_flush  out  1  clear IF/ID to nop.
REQ-018 SHALL have port idex_we  out  1  ID/EX register write enable.
REQ-019 SHALL have port idex_bubble  out  1  load nop into ID/EX.
REQ-020 SHALL have port md_busy  out  1  mult/div sequence in progress.
REQ-021 SHALL have port stall_cycles  out  16  performance count of cycles with pc_we=0.

Function
REQ-022 SHALL implement FSM states RUN and MD_WAIT plus 5-bit down-counter md_cnt.
REQ-023 mem_freeze = mem_req & ~mem_ready; SHALL force pc_we=ifid_we=idex_we=0, ifid_flush=idex_bubble=0; highest priority; any state.
REQ-024 MD_WAIT (not frozen): SHALL drive pc_we=ifid_we=idex_we=0, no flush/bubble, md_busy=1.
REQ-025 RUN, ex_branch_taken=1: SHALL drive pc_we=1, ifid_flush=1, idex_bubble=1, idex_we=1; overrides load-use and jump.
REQ-026 RUN, load-use (ex_memread & ex_rt!=0 & (ex_rt==id_rs | id_uses_rt & ex_rt==id_rt)): SHALL drive pc_we=0, ifid_we=0, idex_bubble=1, idex_we=1.
REQ-027 RUN, (id_jump | id_jumpreg), no load-use: SHALL drive pc_we=1, ifid_flush=1, idex_we=1; no delay slot.
REQ-028 RUN, no event: SHALL drive pc_we=ifid_we=idex_we=1, flush/bubble 0.
REQ-029 RUN -> MD_WAIT SHALL occur when md_start & ~mem_freeze; md_cnt loads 31 (div) or 3 (mult).
REQ-030 md_start with ex_branch_taken SHALL apply REQ-025 outputs and still enter MD_WAIT.
REQ-031 MD_WAIT SHALL decrement md_cnt every cycle, mem_freeze included; md_cnt==0 -> RUN next edge; stall length 32 / 4 cycles.
REQ-032 md_start SHALL be ignored in MD_WAIT.
REQ-033 stall_cycles SHALL increment on each edge with rst_n=1 and pc_we=0, saturating at 0xFFFF.

Reset
REQ-034 rst_n low SHALL asynchronously force state=RUN, md_cnt=0, stall_cycles=0.
REQ-035 While rst_n low, SHALL drive pc_we=ifid_we=idex_we=0, ifid_flush=idex_bubble=0, md_busy=0.
REQ-036 Reset mid-MD_WAIT SHALL abort the sequence; first cycle after release is RUN.

Structure
REQ-037 Shared package SHALL hold state encoding (RUN=0, MD_WAIT=1) and constants MD_DIV_CYC=31, MD_MUL_CYC=3.
REQ-038 Saturating perf counter SHALL be sub-module sat_counter16 (clk, rst_n, inc, count).

Verification
REQ-039 ex_memread=1, ex_rt=8, id_rs=8 -> one cycle pc_we=0, ifid_we=0, idex_bubble=1; stall_cycles +1.
REQ-040 ex_memread=1, ex_rt=0, id_rs=0 -> no stall, all enables 1.
REQ-041 md_start=1, md_is_div=1 -> md_busy=1 exactly 32 cycles, pc_we=0 throughout, RUN after; stall_cycles +32.
REQ-042 ex_branch_taken=1 with load-use -> ifid_flush=1, idex_bubble=1, pc_we=1.
REQ-043 mem_req=1, mem_ready=0 for 3 cycles during mult -> enables 0; md_busy drops after 4 total cycles.
REQ-044 rst_n low at MD_WAIT cycle 10 -> outputs at reset values immediately; stall_cycles=0; RUN after release.
